// File: rtl/arbiter_lv1_lv2.sv
// Round-robin arbiter for the shared lv1-lv2 bus: one processor owner at a
// time (dl/il per core), plus one snoop grant to a core other than the owner's.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   bus_lv1_lv2_req_proc     : processor requests, 2*c = core c dl, 2*c+1 = core c il
//   bus_lv1_lv2_req_snoop    : snoop requests, one per core
//   bus_lv1_lv2_gnt_proc     : registered one-hot-or-zero processor grant
//   bus_lv1_lv2_gnt_snoop    : registered one-hot-or-zero snoop grant
//   bus_busy                 : OR of all grant bits
//   proc_owner               : index of current processor owner, 0 when none
module arbiter_lv1_lv2 #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_PROC_REQ = 2 * NUM_CORES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PROC_REQ-1:0]         bus_lv1_lv2_req_proc,
    input  logic [NUM_CORES-1:0]            bus_lv1_lv2_req_snoop,
    output logic [NUM_PROC_REQ-1:0]         bus_lv1_lv2_gnt_proc,
    output logic [NUM_CORES-1:0]            bus_lv1_lv2_gnt_snoop,
    output logic                            bus_busy,
    output logic [$clog2(NUM_PROC_REQ)-1:0] proc_owner
);

    localparam int PW = $clog2(NUM_PROC_REQ);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        PROC_SNOOP,
        SNOOP_DRAIN
    } state_t;

    state_t                  state, state_n;
    logic [PW-1:0]           rr_proc_ptr, rr_proc_ptr_n;
    logic [CW-1:0]           rr_snoop_ptr, rr_snoop_ptr_n;
    logic [CW-1:0]           snoop_idx, snoop_idx_n;
    logic [NUM_PROC_REQ-1:0] gnt_proc_n;
    logic [NUM_CORES-1:0]    gnt_snoop_n;
    logic [PW-1:0]           proc_owner_n;

    logic                    proc_found;
    logic [PW-1:0]           proc_pick;
    logic                    snoop_found;
    logic [CW-1:0]           snoop_pick;
    logic [CW-1:0]           owner_core;
    logic                    proc_held;
    logic                    snoop_held;
    logic [PW-1:0]           proc_ptr_after;
    logic [CW-1:0]           snoop_ptr_after;
    int                      pidx;
    int                      sidx;

    assign owner_core = CW'(proc_owner >> 1);
    assign proc_held  = bus_lv1_lv2_req_proc[proc_owner];
    assign snoop_held = bus_lv1_lv2_req_snoop[snoop_idx];

    // Pointer values used when the current owner / snoop holder releases.
    assign proc_ptr_after  = (proc_owner == PW'(NUM_PROC_REQ - 1)) ?
                             '0 : proc_owner + PW'(1);
    assign snoop_ptr_after = (snoop_idx == CW'(NUM_CORES - 1)) ?
                             '0 : snoop_idx + CW'(1);

    assign bus_busy = (|bus_lv1_lv2_gnt_proc) || (|bus_lv1_lv2_gnt_snoop);

    // First requesting processor at or after rr_proc_ptr, wrapping.
    always_comb begin
        proc_found = 1'b0;
        proc_pick  = '0;
        pidx       = 0;
        for (int i = 0; i < NUM_PROC_REQ; i++) begin
            pidx = int'(rr_proc_ptr) + i;
            if (pidx >= NUM_PROC_REQ)
                pidx = pidx - NUM_PROC_REQ;
            if (!proc_found && bus_lv1_lv2_req_proc[PW'(pidx)]) begin
                proc_found = 1'b1;
                proc_pick  = PW'(pidx);
            end
        end
    end

    // First snooping core at or after rr_snoop_ptr, skipping the owner's core.
    always_comb begin
        snoop_found = 1'b0;
        snoop_pick  = '0;
        sidx        = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sidx = int'(rr_snoop_ptr) + i;
            if (sidx >= NUM_CORES)
                sidx = sidx - NUM_CORES;
            if (!snoop_found && bus_lv1_lv2_req_snoop[CW'(sidx)] &&
                (CW'(sidx) != owner_core)) begin
                snoop_found = 1'b1;
                snoop_pick  = CW'(sidx);
            end
        end
    end

    always_comb begin
        state_n        = state;
        gnt_proc_n     = bus_lv1_lv2_gnt_proc;
        gnt_snoop_n    = bus_lv1_lv2_gnt_snoop;
        proc_owner_n   = proc_owner;
        snoop_idx_n    = snoop_idx;
        rr_proc_ptr_n  = rr_proc_ptr;
        rr_snoop_ptr_n = rr_snoop_ptr;
        unique case (state)
            IDLE: begin
                if (proc_found) begin
                    gnt_proc_n            = '0;
                    gnt_proc_n[proc_pick] = 1'b1;
                    proc_owner_n          = proc_pick;
                    state_n               = PROC;
                end
            end
            PROC: begin
                if (!proc_held) begin
                    gnt_proc_n    = '0;
                    proc_owner_n  = '0;
                    rr_proc_ptr_n = proc_ptr_after;
                    state_n       = IDLE;
                end else if (snoop_found) begin
                    gnt_snoop_n             = '0;
                    gnt_snoop_n[snoop_pick] = 1'b1;
                    snoop_idx_n             = snoop_pick;
                    state_n                 = PROC_SNOOP;
                end
            end
            PROC_SNOOP: begin
                if (!proc_held) begin
                    gnt_proc_n    = '0;
                    proc_owner_n  = '0;
                    rr_proc_ptr_n = proc_ptr_after;
                end
                if (!snoop_held) begin
                    gnt_snoop_n    = '0;
                    rr_snoop_ptr_n = snoop_ptr_after;
                end
                if (!proc_held && !snoop_held)
                    state_n = IDLE;
                else if (!proc_held)
                    state_n = SNOOP_DRAIN;
                else if (!snoop_held)
                    state_n = PROC;
            end
            SNOOP_DRAIN: begin
                if (!snoop_held) begin
                    gnt_snoop_n    = '0;
                    rr_snoop_ptr_n = snoop_ptr_after;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            bus_lv1_lv2_gnt_proc  <= '0;
            bus_lv1_lv2_gnt_snoop <= '0;
            proc_owner            <= '0;
            snoop_idx             <= '0;
            rr_proc_ptr           <= '0;
            rr_snoop_ptr          <= '0;
        end else begin
            state                 <= state_n;
            bus_lv1_lv2_gnt_proc  <= gnt_proc_n;
            bus_lv1_lv2_gnt_snoop <= gnt_snoop_n;
            proc_owner            <= proc_owner_n;
            snoop_idx             <= snoop_idx_n;
            rr_proc_ptr           <= rr_proc_ptr_n;
            rr_snoop_ptr          <= rr_snoop_ptr_n;
        end
    end

endmodule

// File: tb/tb_arbiter_lv1_lv2.sv
// Testbench for arbiter_lv1_lv2: directed scenarios plus random requests,
// expected grants come from an owner/holder model kept in the bench.
module tb_arbiter_lv1_lv2;

    localparam int NC = 4;
    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req_p = '0;
    logic [NC-1:0] req_s = '0;
    logic [NP-1:0] gnt_p;
    logic [NC-1:0] gnt_s;
    logic          busy;
    logic [2:0]    owner;

    arbiter_lv1_lv2 #(.NUM_CORES(NC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus_lv1_lv2_req_proc  (req_p),
        .bus_lv1_lv2_req_snoop (req_s),
        .bus_lv1_lv2_gnt_proc  (gnt_p),
        .bus_lv1_lv2_gnt_snoop (gnt_s),
        .bus_busy              (busy),
        .proc_owner            (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] gp;
        logic [NC-1:0] gs;
        logic [2:0]    own;
        logic          bsy;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: who owns the bus (-1 none), who holds a snoop grant (-1 none).
    int m_owner = -1;
    int m_snoop = -1;
    int m_rrp = 0;
    int m_rrs = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [NP-1:0] rp, input logic [NC-1:0] rs,
                              input logic r);
        int  c;
        bit  pd, sd;
        if (r) begin
            m_owner = -1; m_snoop = -1; m_rrp = 0; m_rrs = 0;
        end else if (m_owner < 0 && m_snoop < 0) begin
            for (int i = 0; i < NP; i++) begin
                c = (m_rrp + i) % NP;
                if (rp[c[2:0]]) begin m_owner = c; break; end
            end
        end else if (m_owner >= 0 && m_snoop < 0) begin
            if (!rp[m_owner[2:0]]) begin
                m_rrp = (m_owner + 1) % NP;
                m_owner = -1;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    c = (m_rrs + i) % NC;
                    if (c != m_owner / 2 && rs[c[1:0]]) begin m_snoop = c; break; end
                end
            end
        end else if (m_owner >= 0) begin
            pd = !rp[m_owner[2:0]];
            sd = !rs[m_snoop[1:0]];
            if (pd) begin m_rrp = (m_owner + 1) % NP; m_owner = -1; end
            if (sd) begin m_rrs = (m_snoop + 1) % NC; m_snoop = -1; end
        end else begin
            if (!rs[m_snoop[1:0]]) begin m_rrs = (m_snoop + 1) % NC; m_snoop = -1; end
        end
    endtask

    task automatic cyc(input logic [NP-1:0] rp, input logic [NC-1:0] rs,
                       input logic r);
        exp_t e;
        @(negedge clk);
        req_p = rp;
        req_s = rs;
        rst   = r;
        model_step(rp, rs, r);
        e.gp = '0;
        e.gs = '0;
        e.own = '0;
        if (m_owner >= 0) begin
            e.gp[m_owner[2:0]] = 1'b1;
            e.own = m_owner[2:0];
        end
        if (m_snoop >= 0) e.gs[m_snoop[1:0]] = 1'b1;
        e.bsy = (e.gp != 0) || (e.gs != 0);
        q.push_back(e);
    endtask

    // Monitor: every edge whose inputs were modelled yields one expected entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt_proc", int'(gnt_p), int'(e.gp));
            chk("gnt_snoop", int'(gnt_s), int'(e.gs));
            chk("proc_owner", int'(owner), int'(e.own));
            chk("bus_busy", int'(busy), int'(e.bsy));
            chk("onehot_proc", int'($countones(gnt_p) <= 1), 1);
            chk("onehot_snoop", int'($countones(gnt_s) <= 1), 1);
            if (gnt_p != 0 && gnt_s != 0)
                chk("snoop_not_owner_core", int'(gnt_s[owner[2:1]]), 0);
        end
    end

    initial begin
        logic [NP-1:0] rp;
        logic [NC-1:0] rs;
        int last, age;

        repeat (2) cyc('0, '0, 1'b1);

        // Two requesters, owner release, one idle cycle, next owner.
        repeat (3) cyc(8'b0000_0101, '0, 1'b0);
        repeat (4) cyc(8'b0000_0100, '0, 1'b0);
        repeat (2) cyc('0, '0, 1'b0);

        // Core 1 dl owner; snoops from cores 0,1,2.
        cyc('0, '0, 1'b1);
        repeat (2) cyc(8'b0000_0100, 4'b0000, 1'b0);
        repeat (3) cyc(8'b0000_0100, 4'b0111, 1'b0);
        repeat (4) cyc(8'b0000_0100, 4'b0110, 1'b0);
        repeat (2) cyc(8'b0000_0100, 4'b0010, 1'b0);
        repeat (2) cyc('0, 4'b0010, 1'b0);
        repeat (2) cyc('0, '0, 1'b0);

        // Owner leaves while snoop granted: drain.
        repeat (2) cyc(8'b0000_0001, 4'b0000, 1'b0);
        repeat (2) cyc(8'b0000_0001, 4'b0100, 1'b0);
        repeat (3) cyc('0, 4'b0100, 1'b0);
        repeat (2) cyc('0, '0, 1'b0);

        // Reset in the middle of a snoop transaction, requests held.
        repeat (4) cyc('1, '1, 1'b0);
        cyc('1, '1, 1'b1);
        repeat (3) cyc('1, '1, 1'b0);
        repeat (3) cyc('0, '0, 1'b0);

        // All proc requests held, each owner drops 3 cycles into its grant.
        cyc('0, '0, 1'b1);
        last = -2;
        age  = 0;
        for (int k = 0; k < 60; k++) begin
            if (m_owner != last) begin last = m_owner; age = 0; end
            else age++;
            rp = '1;
            if (m_owner >= 0 && age >= 3) rp[m_owner[2:0]] = 1'b0;
            cyc(rp, '0, 1'b0);
        end

        // Random traffic: requests toggle occasionally, rare resets.
        rp = '0;
        rs = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < NP; b++) begin
                case ($urandom_range(0, 7))
                    0: rp[b] = 1'b1;
                    1: rp[b] = 1'b0;
                    default: ;
                endcase
            end
            for (int b = 0; b < NC; b++) begin
                case ($urandom_range(0, 5))
                    0: rs[b] = 1'b1;
                    1: rs[b] = 1'b0;
                    default: ;
                endcase
            end
            cyc(rp, rs, ($urandom_range(0, 99) == 0));
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
